rom_weight_loader: RTL and testbench

- Write-side companion to the per-neuron weight ROMs: accepts a serial stream of weight words over a valid/ready handshake and programs them into a bank of NUM_NEURONS ROMs through each ROM's data/write-enable/address write port.
- Sits between the off-chip/host weight source and a layer's neuron ROMs; one loader per layer.
- Fills neuron 0 address 0..WORDS-1, then neuron 1, and so on, then reports done.

---
 rtl/rom_weight_loader.sv | 164 ++++++++++++++++
 tb/tb_rom_weight_loader.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/rom_weight_loader.sv
// Streams weight words into a bank of per-neuron ROM write ports, neuron by neuron.
// Optional LOADER_CHECKSUM_EN adds a 16-bit running sum of accepted words on checksum_o.
module rom_weight_loader #(
    parameter int depth       = 3,
    parameter int width       = 8,
    parameter int WORDS       = 8,
    parameter int NUM_NEURONS = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic                   valid_i,
    input  logic [width-1:0]       data_i,
    output logic                   ready_o,
    output logic [depth-1:0]       addr_o,
    output logic [width-1:0]       data_o,
    output logic [NUM_NEURONS-1:0] wen_o,
    output logic                   busy_o,
    output logic                   done_o
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [15:0]            checksum_o
`endif
);

    localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [depth-1:0] LAST_WORD   = depth'(WORDS - 1);
    localparam logic [NW-1:0]    LAST_NEURON = NW'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [depth-1:0]  word_cnt_r;
    logic [NW-1:0]     neuron_cnt_r;
    logic              hs_s;
    logic              clear_s;
    logic              last_word_s;
    logic              last_neuron_s;

    // Decode a neuron index into its write-enable lane.
    function automatic logic [NUM_NEURONS-1:0] onehot(input logic [NW-1:0] idx);
        logic [NUM_NEURONS-1:0] v;
        v = '0;
        for (int n = 0; n < NUM_NEURONS; n++) begin
            v[n] = (idx == NW'(n));
        end
        return v;
    endfunction

    assign ready_o       = (state_r == ST_LOAD);
    assign busy_o        = (state_r == ST_LOAD);
    assign done_o        = (state_r == ST_DONE);
    assign hs_s          = valid_i & ready_o;
    assign clear_s       = start_i & (state_r != ST_LOAD);
    assign last_word_s   = (word_cnt_r == LAST_WORD);
    assign last_neuron_s = (neuron_cnt_r == LAST_NEURON);

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; start_i only matters outside LOAD.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (hs_s && last_word_s && last_neuron_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_DONE: begin
                if (start_i) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Word/neuron counters: word wraps into the next neuron with no bubble.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            word_cnt_r   <= '0;
            neuron_cnt_r <= '0;
        end else if (clear_s) begin
            word_cnt_r   <= '0;
            neuron_cnt_r <= '0;
        end else if (hs_s) begin
            if (last_word_s) begin
                word_cnt_r <= '0;
                if (last_neuron_s) begin
                    neuron_cnt_r <= '0;
                end else begin
                    neuron_cnt_r <= neuron_cnt_r + NW'(1);
                end
            end else begin
                word_cnt_r <= word_cnt_r + depth'(1);
            end
        end else begin
            word_cnt_r   <= word_cnt_r;
            neuron_cnt_r <= neuron_cnt_r;
        end
    end

    // Write port: one registered write per handshake; address/data hold when idle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            addr_o <= '0;
            data_o <= '0;
            wen_o  <= '0;
        end else if (hs_s) begin
            addr_o <= word_cnt_r;
            data_o <= data_i;
            wen_o  <= onehot(neuron_cnt_r);
        end else begin
            addr_o <= addr_o;
            data_o <= data_o;
            wen_o  <= '0;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [15:0] checksum_r;

    // Running sum of accepted words, restarted on every LOAD entry.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            checksum_r <= 16'd0;
        end else if (clear_s) begin
            checksum_r <= 16'd0;
        end else if (hs_s) begin
            checksum_r <= checksum_r + 16'(data_i);
        end else begin
            checksum_r <= checksum_r;
        end
    end

    assign checksum_o = checksum_r;
`endif

endmodule

// File: tb/tb_rom_weight_loader.sv
// Randomized bench for rom_weight_loader against a flat-index reference model.
module tb_rom_weight_loader;

    localparam int DEPTH = 3;
    localparam int WIDTH = 8;
    localparam int WORDS = 8;
    localparam int NN    = 4;
    localparam int TOTAL = WORDS * NN;

    logic             clk = 1'b0;
    logic             reset_i = 1'b1;
    logic             start_i = 1'b0;
    logic             valid_i = 1'b0;
    logic [WIDTH-1:0] data_i = '0;
    logic             ready;
    logic [DEPTH-1:0] addr;
    logic [WIDTH-1:0] data;
    logic [NN-1:0]    wen;
    logic             busy;
    logic             done;
`ifdef LOADER_CHECKSUM_EN
    logic [15:0]      checksum;
`endif

    rom_weight_loader #(
        .depth(DEPTH), .width(WIDTH), .WORDS(WORDS), .NUM_NEURONS(NN)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .valid_i(valid_i),
        .data_i(data_i), .ready_o(ready), .addr_o(addr), .data_o(data),
        .wen_o(wen), .busy_o(busy), .done_o(done)
`ifdef LOADER_CHECKSUM_EN
        , .checksum_o(checksum)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: phase 0=idle 1=load 2=done; k = words accepted so far in this load.
    int               phase = 0;
    int               k = 0;
    logic [NN-1:0]    e_wen = '0;
    logic [DEPTH-1:0] e_addr = '0;
    logic [WIDTH-1:0] e_data = '0;
    int               e_sum = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check_eq("ready", 32'(ready), 32'(phase == 1));
        check_eq("busy",  32'(busy),  32'(phase == 1));
        check_eq("done",  32'(done),  32'(phase == 2));
        check_eq("wen",   32'(wen),   32'(e_wen));
        check_eq("addr",  32'(addr),  32'(e_addr));
        check_eq("data",  32'(data),  32'(e_data));
`ifdef LOADER_CHECKSUM_EN
        check_eq("checksum", 32'(checksum), 32'(e_sum));
`endif
    endtask

    // Advance the model by one clock edge using the inputs just driven.
    task automatic model_edge(input logic r, input logic s, input logic v, input logic [WIDTH-1:0] d);
        int old_phase;
        old_phase = phase;
        if (r) begin
            phase = 0; k = 0; e_wen = '0; e_addr = '0; e_data = '0; e_sum = 0;
        end else begin
            if (old_phase == 1 && v) begin
                e_wen  = NN'(1 << (k / WORDS));
                e_addr = DEPTH'(k % WORDS);
                e_data = d;
                e_sum  = (e_sum + int'(d)) % 65536;
                k++;
                if (k == TOTAL) phase = 2;
            end else begin
                e_wen = '0;
            end
            if (old_phase != 1 && s) begin
                phase = 1; k = 0; e_sum = 0;
            end
        end
    endtask

    // One cycle: check outputs from the previous edge, then drive and predict the next.
    task automatic step(input logic r, input logic s, input logic v, input logic [WIDTH-1:0] d);
        @(negedge clk);
        check_all();
        reset_i = r; start_i = s; valid_i = v; data_i = d;
        model_edge(r, s, v, d);
    endtask

    initial begin
        model_edge(1'b1, 1'b0, 1'b0, '0);
        // reset for two cycles, then idle with noisy valid/data
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b1, 8'h3C);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'($urandom), 8'($urandom));

        // full back-to-back load 0x00..0x1F, then linger in DONE
        step(1'b0, 1'b1, 1'b1, 8'hEE);
        for (int i = 0; i < TOTAL; i++) step(1'b0, 1'b0, 1'b1, 8'(i));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'($urandom), 8'($urandom));
`ifdef LOADER_CHECKSUM_EN
        check_eq("checksum_full", 32'(e_sum), 32'h01F0);
`endif

        // reload from DONE with 0xA5, start pulsed again mid-load (ignored)
        step(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < TOTAL; i++) step(1'b0, (i == 4), 1'b1, 8'hA5);
        step(1'b0, 1'b0, 1'b0, '0);

        // reset after 10 accepted words, then restart
        step(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 8'($urandom));
        step(1'b1, 1'b0, 1'b1, 8'h77);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);

        // stall pattern 1,0,0,1
        step(1'b0, 1'b0, 1'b1, 8'h11);
        step(1'b0, 1'b0, 1'b0, 8'h22);
        step(1'b0, 1'b0, 1'b0, 8'h33);
        step(1'b0, 1'b0, 1'b1, 8'h44);
        step(1'b0, 1'b0, 1'b0, 8'h55);

        // random traffic with occasional starts and resets
        for (int i = 0; i < 800; i++) begin
            step(1'($urandom_range(99) < 1),
                 1'($urandom_range(99) < 4),
                 1'($urandom_range(99) < 75),
                 8'($urandom));
        end
        @(negedge clk);
        check_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
